// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ack byte handshake, frame error pulse and sticky overrun.
// Optional parity (11-bit frames) is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned clk_freq  = 10000000,
  parameter int unsigned baud_rate = 9600
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          parity_odd = 1'b0
`endif
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;
  logic [CntW-1:0] clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bad;

`ifdef UART_RX_PARITY_EN
  logic            parity_bit;
  assign par_bad = ((^shift) ^ parity_bit) != parity_odd;
`else
  assign par_bad = 1'b0;
`endif

  assign busy = (state != StIdle);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Placed before the state case so a delivery in the same cycle overrides the clear.
      if (rx_ack && rx_valid) rx_valid <= 1'b0;

      case (state)
        StIdle: begin
          if (rx_prev && !rx_s) begin
            clk_cnt <= '0;
            state   <= StStart;
          end
        end
        StStart: begin
          if (clk_cnt == HalfLast) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? StIdle : StData;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (clk_cnt == BitLast) begin
            clk_cnt        <= '0;
            shift[bit_cnt] <= rx_s;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (clk_cnt == BitLast) begin
            clk_cnt    <= '0;
            parity_bit <= rx_s;
            state      <= StStop;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        StStop: begin
          if (clk_cnt == BitLast) begin
            clk_cnt <= '0;
            state   <= StIdle;
            if (!rx_s) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad) parity_err <= 1'b1;
`endif
            if (rx_s && !par_bad) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) overrun <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
